obj_line_scan: RTL and testbench



---
 rtl/obj_line_scan.sv | 215 +++++++++++++++++++++
 tb/tb_obj_line_scan.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/obj_line_scan.sv
// OAM line scanner: walks OAM once per start_row and queues visible object indices in a FWFT list FIFO.
// Optional OBJ_LINE_SCAN_WINDOW_EN: list mode-2 (OBJ window) objects with a window flag instead of skipping them.
module obj_line_scan #(
    parameter int NUM_OBJ       = 128,
    parameter int LIST_DEPTH    = 32,
    parameter int LINE_CYCLES   = 1232,
    parameter int HBLANK_CYCLES = 954,
    parameter int OAM_LAT       = 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start_row,
    input  logic [7:0]                    row,
    input  logic                          hblank_free,
    output logic                          oam_rd,
    output logic [9:0]                    oam_addr,
    input  logic [31:0]                   oam_data,
    output logic                          list_valid,
    input  logic                          list_ready,
    output logic [6:0]                    list_obj,
    output logic                          list_win,
    output logic [$clog2(LIST_DEPTH):0]   list_count,
    output logic                          scan_busy,
    output logic                          scan_done,
    output logic                          budget_hit
);
    localparam int AW = $clog2(LIST_DEPTH);
    localparam int CW = AW + 1;
`ifdef OBJ_LINE_SCAN_WINDOW_EN
    localparam int EW = 8;
`else
    localparam int EW = 7;
`endif

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, DONE} state_t;

    state_t         r_state, w_next;
    logic [6:0]     r_idx, w_idx_next;
    logic [15:0]    r_cyc, r_budget_m1;
    logic [7:0]     r_row;
    logic [1:0]     r_wait;
    logic [7:0]     r_y;
    logic           r_rot, r_dbl;
    logic [1:0]     r_mode, r_shape, r_size;
    logic           r_oam_rd, r_busy, r_done, r_budget_hit;
    logic [9:0]     r_oam_addr;
    logic [EW-1:0]  r_mem [LIST_DEPTH];
    logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic           w_push, w_pop, w_full, w_adv, w_skip, w_visible, w_budget_end;
    logic [8:0]     w_height;
    logic [7:0]     w_diff;
    logic [EW-1:0]  w_entry, w_head;
    logic           w_unused_ok;

    assign w_unused_ok = ^{oam_data[29:16], oam_data[13:12]};

    // Object decode and row test on the attribute fields captured on entry to EVAL.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_height = 9'd8;
        case (r_shape)
            2'd0:    case (r_size) 2'd0: w_height = 9'd8;  2'd1: w_height = 9'd16; 2'd2: w_height = 9'd32; default: w_height = 9'd64; endcase
            2'd1:    case (r_size) 2'd0: w_height = 9'd8;  2'd1: w_height = 9'd8;  2'd2: w_height = 9'd16; default: w_height = 9'd32; endcase
            default: case (r_size) 2'd0: w_height = 9'd16; 2'd1: w_height = 9'd32; 2'd2: w_height = 9'd32; default: w_height = 9'd64; endcase
        endcase
        if (r_rot && r_dbl)
            w_height = w_height << 1;
    end

`ifdef OBJ_LINE_SCAN_WINDOW_EN
    assign w_skip  = (!r_rot && r_dbl) || (r_mode == 2'd3) || (r_shape == 2'd3);
    assign w_entry = {(r_mode == 2'd2), r_idx};
`else
    assign w_skip  = (!r_rot && r_dbl) || (r_mode == 2'd3) || (r_shape == 2'd3) || (r_mode == 2'd2);
    assign w_entry = r_idx;
`endif
    assign w_diff       = r_row - r_y;
    assign w_visible    = !w_skip && ({1'b0, w_diff} < w_height);
    assign w_full       = (r_count == CW'(LIST_DEPTH));
    assign w_pop        = list_ready && (r_count != '0) && !start_row;
    assign w_budget_end = (r_state == ISSUE || r_state == WAIT || r_state == EVAL) && (r_cyc == r_budget_m1);

    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        w_adv  = 1'b0;
        case (r_state)
            ISSUE: w_next = WAIT;
            WAIT:  if (r_wait == 2'(OAM_LAT - 1)) w_next = EVAL;
            EVAL: begin
                if (!w_visible)
                    w_adv = 1'b1;
                else if (!w_full || w_pop) begin
                    w_push = 1'b1;
                    w_adv  = 1'b1;
                end
                if (w_adv)
                    w_next = (r_idx == 7'(NUM_OBJ - 1)) ? DONE : ISSUE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_budget_end)
            w_next = DONE;
        // A restart flushes the list, so a push in the same cycle is dropped with it.
        if (start_row) begin
            w_next = ISSUE;
            w_push = 1'b0;
        end
        w_idx_next = r_idx;
        if (start_row)
            w_idx_next = '0;
        else if (w_adv && w_next == ISSUE)
            w_idx_next = r_idx + 7'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            // NOTE: sequential state always uses non-blocking assignment so every register samples pre-edge values.
            r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx        <= '0;
            r_cyc        <= '0;
            r_budget_m1  <= '0;
            r_row        <= '0;
            r_wait       <= '0;
            r_y          <= '0;
            r_rot        <= 1'b0;
            r_dbl        <= 1'b0;
            r_mode       <= '0;
            r_shape      <= '0;
            r_size       <= '0;
            r_oam_rd     <= 1'b0;
            r_oam_addr   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_budget_hit <= 1'b0;
        end else begin
            r_idx    <= w_idx_next;
            r_wait   <= (r_state == WAIT && w_next == WAIT) ? r_wait + 2'd1 : 2'd0;
            r_oam_rd <= (w_next == ISSUE);
            r_busy   <= (w_next != IDLE);
            r_done   <= (w_next == DONE);
            if (w_next == ISSUE)
                r_oam_addr <= {2'b00, w_idx_next, 1'b0};
            if (r_state == WAIT && w_next == EVAL) begin
                r_y     <= oam_data[7:0];
                r_rot   <= oam_data[8];
                r_dbl   <= oam_data[9];
                r_mode  <= oam_data[11:10];
                r_shape <= oam_data[15:14];
                r_size  <= oam_data[31:30];
            end
            if (start_row) begin
                r_cyc        <= '0;
                r_budget_hit <= 1'b0;
                r_row        <= row;
                r_budget_m1  <= hblank_free ? 16'(HBLANK_CYCLES - 1) : 16'(LINE_CYCLES - 1);
            end else begin
                if (r_state == ISSUE || r_state == WAIT || r_state == EVAL)
                    r_cyc <= r_cyc + 16'd1;
                if (w_budget_end)
                    r_budget_hit <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (start_row) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: list storage is not reset; the head outputs are gated by list_valid so stale words never escape.
    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_entry;
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign list_valid = (r_count != '0);
    assign list_obj   = list_valid ? w_head[6:0] : 7'd0;
`ifdef OBJ_LINE_SCAN_WINDOW_EN
    assign list_win   = list_valid & w_head[7];
`else
    assign list_win   = 1'b0;
`endif
    assign list_count = r_count;
    assign oam_rd     = r_oam_rd;
    assign oam_addr   = r_oam_addr;
    assign scan_busy  = r_busy;
    assign scan_done  = r_done;
    assign budget_hit = r_budget_hit;
endmodule

// File: tb/tb_obj_line_scan.sv
// Directed bench for obj_line_scan: OAM model, scoreboard queue filled at scan start, drained on list pops.
module tb_obj_line_scan;
    logic        clock = 1'b0;
    logic        reset_n, start_row, hblank_free, list_ready;
    logic [7:0]  row;
    logic        oam_rd, list_valid, list_win, scan_busy, scan_done, budget_hit;
    logic [9:0]  oam_addr;
    logic [31:0] oam_data;
    logic [6:0]  list_obj;
    logic [5:0]  list_count;

    logic [31:0] oam_obj [128];
    logic [7:0]  exp_q [$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_pops, done_cyc, n_done;
    logic        bh;

    obj_line_scan #(.HBLANK_CYCLES(300)) dut (
        .clock(clock), .reset_n(reset_n), .start_row(start_row), .row(row),
        .hblank_free(hblank_free), .oam_rd(oam_rd), .oam_addr(oam_addr),
        .oam_data(oam_data), .list_valid(list_valid), .list_ready(list_ready),
        .list_obj(list_obj), .list_win(list_win), .list_count(list_count),
        .scan_busy(scan_busy), .scan_done(scan_done), .budget_hit(budget_hit)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (oam_rd) oam_data <= oam_obj[oam_addr[7:1]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit tb_visible(input logic [31:0] w, input int r);
        int y, shape, size, mode, h;
        y = int'(w[7:0]); shape = int'(w[15:14]); mode = int'(w[11:10]); size = int'(w[31:30]);
        if (!w[8] && w[9]) return 1'b0;
        if (mode == 3 || shape == 3) return 1'b0;
`ifndef OBJ_LINE_SCAN_WINDOW_EN
        if (mode == 2) return 1'b0;
`endif
        if (shape == 0)      h = 8 << size;
        else if (shape == 1) h = (size == 0) ? 8 : (4 << size);
        else                 h = (size == 0) ? 16 : ((size == 3) ? 64 : 32);
        if (w[8] && w[9]) h = h * 2;
        if (h > 128) h = 128;
        return ((r - y + 256) % 256) < h;
    endfunction

    function automatic bit tb_win(input logic [31:0] w);
`ifdef OBJ_LINE_SCAN_WINDOW_EN
        return w[11:10] == 2'd2;
`else
        return 1'b0;
`endif
    endfunction

    task automatic fill(input logic [31:0] w, input int first, input int last);
        for (int i = 0; i < 128; i++)
            oam_obj[i] = (i >= first && i <= last) ? w : 32'h0000_0200;
    endtask

    // Called just after a posedge; leaves the bench 1 time unit after the posedge that samples start_row.
    task automatic start_scan(input int r, input bit hb, input int last);
        exp_q.delete();
        for (int i = 0; i <= last; i++)
            if (tb_visible(oam_obj[i], r)) exp_q.push_back({tb_win(oam_obj[i]), 7'(i)});
        row = 8'(r); hblank_free = hb; start_row = 1'b1;
        @(posedge clock); #1;
        start_row = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic drain(input int max_cyc, output int pops, output int dcyc, output int ndone, output logic bh_done);
        int cyc = 0;
        bit fin = 1'b0;
        pops = 0; dcyc = -1; ndone = 0; bh_done = 1'b0;
        while (!fin) begin
            if (list_valid && list_ready) begin
                check("entry expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("entry value", {24'd0, list_win, list_obj}, {24'd0, exp_q.pop_front()});
                pops++;
            end
            if (scan_done) begin ndone++; dcyc = cyc; bh_done = budget_hit; end
            if (ndone > 0 && !scan_busy && !list_valid) fin = 1'b1;
            else if (cyc >= max_cyc) begin
                check("drain timeout", 32'(fin), 32'd1);
                fin = 1'b1;
            end else begin
                @(posedge clock); #1; cyc++;
            end
        end
        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start_row = 1'b0; row = 8'd0; hblank_free = 1'b0; list_ready = 1'b0;
        fill(32'h0, 1, 0);
        step(3);
        check("reset oam_rd", 32'(oam_rd), 32'd0);
        check("reset oam_addr", 32'(oam_addr), 32'd0);
        check("reset list", {29'd0, list_valid, list_win, scan_done}, 32'd0);
        check("reset list_obj", 32'(list_obj), 32'd0);
        check("reset list_count", 32'(list_count), 32'd0);
        check("reset busy/hit", {30'd0, scan_busy, budget_hit}, 32'd0);
        reset_n = 1'b1;
        step(2);

        // Single object 5, full scan timing.
        fill(32'h0, 1, 0); oam_obj[5] = 32'h4000_000A;
        list_ready = 1'b1;
        start_scan(20, 1'b0, 127);
        check("busy after start", 32'(scan_busy), 32'd1);
        drain(1000, n_pops, done_cyc, n_done, bh);
        check("obj5 pops", 32'(n_pops), 32'd1);
        check("obj5 done cycle", 32'(done_cyc), 32'd384);
        check("obj5 budget_hit", 32'(bh), 32'd0);
        check("obj5 done pulses", 32'(n_done), 32'd1);

        // Row wrap-around.
        fill(32'h0, 1, 0); oam_obj[7] = 32'h0000_80FA;
        start_scan(5, 1'b0, 127);
        drain(1000, n_pops, done_cyc, n_done, bh);
        check("wrap row5 pops", 32'(n_pops), 32'd1);
        start_scan(10, 1'b0, 127);
        drain(1000, n_pops, done_cyc, n_done, bh);
        check("wrap row10 pops", 32'(n_pops), 32'd0);

        // Rotated double-size versus disabled.
        fill(32'h0, 1, 0); oam_obj[3] = 32'hC000_0300;
        start_scan(100, 1'b0, 127);
        drain(1000, n_pops, done_cyc, n_done, bh);
        check("rotdbl pops", 32'(n_pops), 32'd1);
        oam_obj[3] = 32'hC000_0200;
        start_scan(100, 1'b0, 127);
        drain(1000, n_pops, done_cyc, n_done, bh);
        check("disabled pops", 32'(n_pops), 32'd0);

        // Back-pressure: 40 visible objects with the consumer stalled.
        fill(32'hC000_0000, 0, 39);
        list_ready = 1'b0;
        start_scan(10, 1'b0, 127);
        step(200);
        check("full count", 32'(list_count), 32'd32);
        check("stalled busy", 32'(scan_busy), 32'd1);
        check("stalled no read", 32'(oam_rd), 32'd0);
        list_ready = 1'b1;
        drain(2000, n_pops, done_cyc, n_done, bh);
        check("stall pops", 32'(n_pops), 32'd40);
        check("stall budget_hit", 32'(bh), 32'd0);

        // Reduced budget stops the scan at object 99.
        fill(32'hC000_0000, 0, 127);
        start_scan(10, 1'b1, 99);
        drain(1000, n_pops, done_cyc, n_done, bh);
        check("budget pops", 32'(n_pops), 32'd100);
        check("budget done cycle", 32'(done_cyc), 32'd300);
        check("budget hit at done", 32'(bh), 32'd1);
        check("budget done pulses", 32'(n_done), 32'd1);
        step(5);
        check("budget_hit sticky", 32'(budget_hit), 32'd1);

        // OBJ-window object.
        fill(32'h0, 1, 0); oam_obj[9] = 32'h0000_0800;
        start_scan(3, 1'b0, 127);
        check("budget_hit cleared", 32'(budget_hit), 32'd0);
        drain(1000, n_pops, done_cyc, n_done, bh);
`ifdef OBJ_LINE_SCAN_WINDOW_EN
        check("window pops", 32'(n_pops), 32'd1);
`else
        check("window pops", 32'(n_pops), 32'd0);
`endif

        // Restart mid-scan flushes and begins again at object 0.
        fill(32'hC000_0000, 0, 39);
        list_ready = 1'b0;
        start_scan(10, 1'b0, 127);
        step(50);
        check("pre-restart count", 32'(list_count != 6'd0), 32'd1);
        start_scan(10, 1'b0, 127);
        check("restart flushed", {26'd0, list_count}, 32'd0);
        check("restart valid", 32'(list_valid), 32'd0);
        check("restart read", {21'd0, oam_rd, oam_addr}, {21'd0, 1'b1, 10'd0});
        list_ready = 1'b1;
        drain(2000, n_pops, done_cyc, n_done, bh);
        check("restart pops", 32'(n_pops), 32'd40);

        // Asynchronous reset in the middle of a stalled scan.
        list_ready = 1'b0;
        start_scan(10, 1'b0, 127);
        step(60);
        #2 reset_n = 1'b0;
        #1;
        check("async rst count", {26'd0, list_count}, 32'd0);
        check("async rst flags", {28'd0, list_valid, scan_busy, oam_rd, budget_hit}, 32'd0);
        check("async rst addr", 32'(oam_addr), 32'd0);
        @(negedge clock) reset_n = 1'b1;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
